// File: rtl/kb_move_sequencer.sv
// Chess-move entry sequencer: collects from/to squares from PS/2 scan codes,
// writes them plus a move-valid flag into data memory, and shares the single
// memory write port with the processor under starvation protection.
module kb_move_sequencer #(
    parameter logic [11:0] FROM_ADDR    = 12'd64,
    parameter logic [11:0] TO_ADDR      = 12'd65,
    parameter logic [11:0] FLAG_ADDR    = 12'd66,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  ps2_key_data,
    input  logic        ps2_key_pressed,
    input  logic        cpu_we,
    input  logic [11:0] cpu_write_address,
    input  logic [31:0] cpu_write_data,
    output logic        mem_we,
    output logic [11:0] mem_write_address,
    output logic [31:0] mem_write_data,
    output logic        cpu_stall,
    output logic        move_pending,
    output logic [1:0]  entry_phase
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [2:0] {
        COLLECT_FROM, WR_FROM, COLLECT_TO, WR_TO, WR_FLAG, WAIT_ACK
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       letter_q, letter_d, number_q, number_d;
    logic             letter_v_q, letter_v_d, number_v_q, number_v_d;
    logic [5:0]       from_sq_q, from_sq_d, to_sq_q, to_sq_d;
    logic             break_q, break_d, ext_q, ext_d;
    logic [CNT_W-1:0] starve_q, starve_d;

    logic       is_letter, is_number, key_live, in_wr, grant;
    logic [2:0] key_file, key_rank;

    // Scan-code decode of letters A..H and digits 1..8
    always_comb begin
        is_letter = 1'b1;
        key_file  = 3'd0;
        case (ps2_key_data)
            8'h1C: key_file = 3'd0;
            8'h32: key_file = 3'd1;
            8'h21: key_file = 3'd2;
            8'h23: key_file = 3'd3;
            8'h24: key_file = 3'd4;
            8'h2B: key_file = 3'd5;
            8'h34: key_file = 3'd6;
            8'h33: key_file = 3'd7;
            default: is_letter = 1'b0;
        endcase
        is_number = 1'b1;
        key_rank  = 3'd0;
        case (ps2_key_data)
            8'h16: key_rank = 3'd0;
            8'h1E: key_rank = 3'd1;
            8'h26: key_rank = 3'd2;
            8'h25: key_rank = 3'd3;
            8'h2E: key_rank = 3'd4;
            8'h36: key_rank = 3'd5;
            8'h3D: key_rank = 3'd6;
            8'h3E: key_rank = 3'd7;
            default: is_number = 1'b0;
        endcase
    end

    assign key_live  = ps2_key_pressed && !break_q && !ext_q;
    assign in_wr     = (state_q == WR_FROM) || (state_q == WR_TO) || (state_q == WR_FLAG);
    assign grant     = in_wr && !reset && (!cpu_we || starve_q == LIMIT);
    assign cpu_stall = in_wr && cpu_we && (starve_q == LIMIT);

    // State and datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= COLLECT_FROM;
            letter_q   <= 3'd0;
            number_q   <= 3'd0;
            letter_v_q <= 1'b0;
            number_v_q <= 1'b0;
            from_sq_q  <= 6'd0;
            to_sq_q    <= 6'd0;
            break_q    <= 1'b0;
            ext_q      <= 1'b0;
            starve_q   <= '0;
        end else begin
            state_q    <= state_d;
            letter_q   <= letter_d;
            number_q   <= number_d;
            letter_v_q <= letter_v_d;
            number_v_q <= number_v_d;
            from_sq_q  <= from_sq_d;
            to_sq_q    <= to_sq_d;
            break_q    <= break_d;
            ext_q      <= ext_d;
            starve_q   <= starve_d;
        end
    end

    // Next-state: key filter, square collection, write sequencing, ack wait
    always_comb begin
        state_d    = state_q;
        letter_d   = letter_q;
        number_d   = number_q;
        letter_v_d = letter_v_q;
        number_v_d = number_v_q;
        from_sq_d  = from_sq_q;
        to_sq_d    = to_sq_q;
        break_d    = break_q;
        ext_d      = ext_q;
        starve_d   = starve_q;

        // Prefix bytes swallow the byte that follows them
        if (ps2_key_pressed) begin
            if (break_q)                    break_d = 1'b0;
            else if (ext_q)                 ext_d   = 1'b0;
            else if (ps2_key_data == 8'hF0) break_d = 1'b1;
            else if (ps2_key_data == 8'hE0) ext_d   = 1'b1;
        end

        case (state_q)
            COLLECT_FROM, COLLECT_TO: begin
                if (key_live) begin
                    if (is_letter) begin
                        letter_d   = key_file;
                        letter_v_d = 1'b1;
                    end
                    if (is_number) begin
                        number_d   = key_rank;
                        number_v_d = 1'b1;
                    end
                    if (ps2_key_data == 8'h66) begin
                        letter_v_d = 1'b0;
                        number_v_d = 1'b0;
                    end
                    if (ps2_key_data == 8'h76 && state_q == COLLECT_TO) begin
                        letter_d   = 3'd0;
                        number_d   = 3'd0;
                        letter_v_d = 1'b0;
                        number_v_d = 1'b0;
                        from_sq_d  = 6'd0;
                        state_d    = COLLECT_FROM;
                    end
                end
                // Square completes on the edge the second half arrives
                if (letter_v_d && number_v_d) begin
                    letter_v_d = 1'b0;
                    number_v_d = 1'b0;
                    if (state_q == COLLECT_FROM) begin
                        from_sq_d = {number_d, letter_d};
                        state_d   = WR_FROM;
                    end else begin
                        to_sq_d = {number_d, letter_d};
                        state_d = WR_TO;
                    end
                end
            end
            WR_FROM, WR_TO, WR_FLAG: begin
                if (grant) begin
                    starve_d = '0;
                    case (state_q)
                        WR_FROM: state_d = COLLECT_TO;
                        WR_TO:   state_d = WR_FLAG;
                        default: state_d = WAIT_ACK;
                    endcase
                end else if (starve_q != LIMIT) begin
                    starve_d = starve_q + CNT_W'(1);
                end
            end
            WAIT_ACK: begin
                if (cpu_we && cpu_write_address == FLAG_ADDR && cpu_write_data == 32'd0)
                    state_d = COLLECT_FROM;
            end
            default: state_d = COLLECT_FROM;
        endcase
    end

    // Memory write-port mux: keyboard write when granted, else processor
    always_comb begin
        mem_we            = cpu_we;
        mem_write_address = cpu_write_address;
        mem_write_data    = cpu_write_data;
        if (grant) begin
            mem_we = 1'b1;
            case (state_q)
                WR_FROM: begin
                    mem_write_address = FROM_ADDR;
                    mem_write_data    = {26'd0, from_sq_q};
                end
                WR_TO: begin
                    mem_write_address = TO_ADDR;
                    mem_write_data    = {26'd0, to_sq_q};
                end
                default: begin
                    mem_write_address = FLAG_ADDR;
                    mem_write_data    = 32'd1;
                end
            endcase
        end
    end

    // Status decode from the current state
    always_comb begin
        move_pending = (state_q == WAIT_ACK);
        case (state_q)
            COLLECT_FROM: entry_phase = 2'd0;
            COLLECT_TO:   entry_phase = 2'd1;
            WAIT_ACK:     entry_phase = 2'd3;
            default:      entry_phase = 2'd2;
        endcase
    end

endmodule
